simmem_mem_responder: RTL

SIMMEM_MEM_RESPONDER -- requirements
Module: simmem_mem_responder

---
 rtl/simmem_mem_responder.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/simmem_mem_responder.sv
// Simulated memory responder: queues read/write addresses, answers reads with
// address-derived data after a fixed latency and acknowledges completed writes.

package simmem_pkg;
    parameter int IdW           = 4;
    parameter int AddrW         = 16;
    parameter int DataW         = 32;
    parameter int MaxRBurstLenW = 3;

    typedef struct packed {
        logic [IdW-1:0]           id;
        logic [AddrW-1:0]         addr;
        logic [MaxRBurstLenW-1:0] burst_len;
    } raddr_t;

    typedef struct packed {
        logic [IdW-1:0]           id;
        logic [MaxRBurstLenW-1:0] burst_len;
    } waddr_t;

    typedef struct packed {
        logic [DataW-1:0] data;
    } wdata_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic             last;
    } rdata_t;

    typedef struct packed {
        logic [IdW-1:0] id;
    } wrsp_t;
endpackage

module simmem_fifo #(
    parameter int  Depth = 4,
    parameter type T     = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PtrW = $clog2(Depth);

    logic [PtrW:0] wptr_q, rptr_q;
    T              mem_q [Depth];

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) wptr_q <= wptr_q + (PtrW+1)'(1);
            if (pop_i && !empty_o) rptr_q <= rptr_q + (PtrW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem_q[wptr_q[PtrW-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rptr_q[PtrW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                     (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
endmodule

module simmem_mem_responder
    import simmem_pkg::*;
#(
    parameter int QueueDepth = 4,
    parameter int RspLatency = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               raddr_valid_i,
    output logic               raddr_ready_o,
    input  simmem_pkg::raddr_t raddr_i,
    input  logic               waddr_valid_i,
    output logic               waddr_ready_o,
    input  simmem_pkg::waddr_t waddr_i,
    input  logic               wdata_valid_i,
    output logic               wdata_ready_o,
    input  simmem_pkg::wdata_t wdata_i,
    output logic               rdata_valid_o,
    input  logic               rdata_ready_i,
    output simmem_pkg::rdata_t rdata_o,
    output logic               wrsp_valid_o,
    input  logic               wrsp_ready_i,
    output simmem_pkg::wrsp_t  wrsp_o
);
    localparam int BeatW = MaxRBurstLenW + 1;
    localparam int LatW  = $clog2(RspLatency + 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} rstate_e;

    raddr_t  raddr_head;
    logic    raddr_full, raddr_empty, raddr_pop;
    waddr_t  waddr_head;
    logic    waddr_full, waddr_empty, waddr_pop;
    wrsp_t   wrsp_head, wrsp_in;
    logic    wrsp_full, wrsp_empty, wrsp_push;

    rstate_e                  state_q, state_d;
    logic [LatW-1:0]          lat_q, lat_d;
    logic [BeatW-1:0]         beat_q, beat_d;
    raddr_t                   hold_q, hold_d;
    logic [MaxRBurstLenW-1:0] wbeat_q, wbeat_d;
    logic                     rlast, wdata_hs;

    // Write data carries no information this model keeps.
    logic unused_wdata;
    assign unused_wdata = ^wdata_i;

    simmem_fifo #(.Depth(QueueDepth), .T(raddr_t)) u_raddr_q (
        .clk_i, .rst_i,
        .push_i (raddr_valid_i && raddr_ready_o),
        .data_i (raddr_i),
        .pop_i  (raddr_pop),
        .data_o (raddr_head),
        .full_o (raddr_full),
        .empty_o(raddr_empty)
    );

    simmem_fifo #(.Depth(QueueDepth), .T(waddr_t)) u_waddr_q (
        .clk_i, .rst_i,
        .push_i (waddr_valid_i && waddr_ready_o),
        .data_i (waddr_i),
        .pop_i  (waddr_pop),
        .data_o (waddr_head),
        .full_o (waddr_full),
        .empty_o(waddr_empty)
    );

    simmem_fifo #(.Depth(QueueDepth), .T(wrsp_t)) u_wrsp_q (
        .clk_i, .rst_i,
        .push_i (wrsp_push),
        .data_i (wrsp_in),
        .pop_i  (wrsp_valid_o && wrsp_ready_i),
        .data_o (wrsp_head),
        .full_o (wrsp_full),
        .empty_o(wrsp_empty)
    );

    assign raddr_ready_o = !raddr_full;
    assign waddr_ready_o = !waddr_full;
    assign wdata_ready_o = !waddr_empty && !wrsp_full;
    assign wdata_hs      = wdata_valid_i && wdata_ready_o;
    assign wrsp_in       = '{id: waddr_head.id};
    assign wrsp_valid_o  = !wrsp_empty;
    assign wrsp_o        = wrsp_empty ? '0 : wrsp_head;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        wbeat_d   = wbeat_q;
        waddr_pop = 1'b0;
        wrsp_push = 1'b0;
        if (wdata_hs) begin
            if (wbeat_q == waddr_head.burst_len) begin
                wbeat_d   = '0;
                waddr_pop = 1'b1;
                wrsp_push = 1'b1;
            end else begin
                wbeat_d = wbeat_q + MaxRBurstLenW'(1);
            end
        end
    end

    assign rlast = (beat_q == {1'b0, hold_q.burst_len});

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        hold_d    = hold_q;
        raddr_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!raddr_empty) begin
                    raddr_pop = 1'b1;
                    hold_d    = raddr_head;
                    lat_d     = LatW'(RspLatency);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - LatW'(1);
                if (lat_q == LatW'(1)) begin
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (rdata_ready_i) begin
                    beat_d = beat_q + BeatW'(1);
                    if (rlast) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_o = '0;
        if (state_q == BURST) begin
            rdata_o.id   = hold_q.id;
            rdata_o.data = DataW'(hold_q.addr) + DataW'(beat_q);
            rdata_o.last = rlast;
        end
    end

    assign rdata_valid_o = (state_q == BURST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            hold_q  <= '0;
            wbeat_q <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            hold_q  <= hold_d;
            wbeat_q <= wbeat_d;
        end
    end
endmodule
